inst_fetch_unit: RTL and testbench

- Supplies the cpu's 32-bit `Inst` stream, replacing direct bench driving of `Inst`.
- Fetches sequential words from a variable-latency instruction memory using a req/ack handshake.
- Buffers fetched words in a small prefetch FIFO.
- Presents each word, with its PC, to the decode stage over a valid/ready handshake.
- Branch/jump redirect flushes the buffer and restarts fetch at a new PC.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/inst_fifo.sv | 43 ++++
 rtl/inst_fetch_unit.sv | 139 +++++++++++++
 tb/tb_inst_fetch_unit.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared cpu front-end constants: instruction width, PC step, NOP encoding and
// the fetch-unit state encoding.
package cpu_pkg;

  localparam int INST_W  = 32;
  localparam int PC_STEP = 4;

  localparam logic [INST_W-1:0] NOP = 32'h0000_0000;

  localparam logic [1:0] IFU_IDLE = 2'd0;
  localparam logic [1:0] IFU_REQ  = 2'd1;
  localparam logic [1:0] IFU_DROP = 2'd2;

endpackage

// File: rtl/inst_fifo.sv
// Prefetch FIFO: DEPTH entries (power of two) with wrap-around pointers,
// synchronous flush, occupancy count and combinational head.
module inst_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: sequential prefetch over an imem req/ack port into a
// small FIFO, redirect flush, decode valid/ready output. Optional IFU_BYPASS_EN.
//
// Handshakes: imem_req stays high with a stable imem_addr until a cycle with
// imem_ack; a decode transfer happens on every cycle with inst_valid & inst_ready.
module inst_fetch_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [1:0]        fsm_state
);

  localparam int                CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0]  FULL  = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(PC_STEP);

  logic [1:0]               state;
  logic [1:0]               state_next;
  logic [ADDR_W-1:0]        fetch_pc;
  logic [ADDR_W-1:0]        fetch_pc_next;
  logic [ADDR_W-1:0]        drop_addr;
  logic [ADDR_W-1:0]        target_pc;
  logic [CNT_W-1:0]         count;
  logic [CNT_W-1:0]         count_next;
  logic [INST_W+ADDR_W-1:0] head;
  logic                     fifo_valid;
  logic                     fifo_pop;
  logic                     push;
  logic                     bypass;

  assign target_pc  = redirect_pc & ~ADDR_W'(3);
  assign fifo_valid = (count != '0);
  assign fifo_pop   = fifo_valid && inst_ready;

`ifdef IFU_BYPASS_EN
  assign bypass = (state == IFU_REQ) && imem_ack && !fifo_valid && !redirect;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed word taken by decode in the same cycle never enters the FIFO.
  assign push       = (state == IFU_REQ) && imem_ack && !redirect && !(bypass && inst_ready);
  assign count_next = count + CNT_W'(push) - CNT_W'(fifo_pop);

  inst_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (INST_W + ADDR_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (fifo_pop),
    .flush (redirect),
    .din   ({imem_rdata, fetch_pc}),
    .count (count),
    .head  (head)
  );

  always_comb begin
    inst_valid = fifo_valid || bypass;
    inst       = NOP;
    inst_pc    = '0;
    if (bypass) begin
      inst    = imem_rdata;
      inst_pc = fetch_pc;
    end else if (fifo_valid) begin
      inst    = head[INST_W+ADDR_W-1:ADDR_W];
      inst_pc = head[ADDR_W-1:0];
    end
  end

  assign imem_req  = (state != IFU_IDLE);
  assign imem_addr = (state == IFU_DROP) ? drop_addr : fetch_pc;
  assign fsm_state = state;

  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    case (state)
      IFU_IDLE: begin
        if (redirect) begin
          fetch_pc_next = target_pc;
          state_next    = IFU_REQ;
        end else if (count_next < FULL) begin
          state_next = IFU_REQ;
        end
      end
      IFU_REQ: begin
        // A redirect without ack must keep the bus address: finish it in DROP.
        if (redirect) begin
          fetch_pc_next = target_pc;
          state_next    = imem_ack ? IFU_REQ : IFU_DROP;
        end else if (imem_ack) begin
          fetch_pc_next = fetch_pc + STEP;
          state_next    = (count_next < FULL) ? IFU_REQ : IFU_IDLE;
        end
      end
      IFU_DROP: begin
        if (redirect) fetch_pc_next = target_pc;
        if (imem_ack) state_next = IFU_REQ;
      end
      default: state_next = IFU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IFU_IDLE;
      fetch_pc  <= RESET_PC;
      drop_addr <= RESET_PC;
    end else begin
      state    <= state_next;
      fetch_pc <= fetch_pc_next;
      if (state == IFU_REQ && redirect && !imem_ack) drop_addr <= fetch_pc;
    end
  end

  a_addr_stable : assert property (@(posedge clk) disable iff (reset)
    (imem_req && !imem_ack) |=> (imem_req && $stable(imem_addr)));

  a_no_overfill : assert property (@(posedge clk) disable iff (reset)
    ((CNT_W+1)'(count) + (CNT_W+1)'(imem_req)) <= (CNT_W+1)'(DEPTH));

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: directed scenarios plus a randomized run, checked
// against a stream model (consecutive PCs from reset or the latest redirect).
`timescale 1ns/1ps
module tb_inst_fetch_unit;
  import cpu_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset = 1'b1;

  logic        imem_req, imem_ack, inst_valid, inst_ready, redirect;
  logic [31:0] imem_addr, imem_rdata, inst, inst_pc, redirect_pc;
  logic [1:0]  fsm_state;

  logic        w_req, w_ack, w_valid;
  logic [31:0] w_addr, w_rdata, w_inst, w_pc;
  logic [1:0]  w_state;

  inst_fetch_unit #(.ADDR_W(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .inst_valid(inst_valid),
    .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready),
    .redirect(redirect), .redirect_pc(redirect_pc), .fsm_state(fsm_state)
  );

  inst_fetch_unit #(.ADDR_W(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .reset(reset), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ack(w_ack), .imem_rdata(w_rdata), .inst_valid(w_valid),
    .inst(w_inst), .inst_pc(w_pc), .inst_ready(1'b1),
    .redirect(1'b0), .redirect_pc(32'h0), .fsm_state(w_state)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];
  logic [31:0] ack_q[$];
  logic [31:0] pop_q[$];
  logic [31:0] w_ack_q[$];
  logic [31:0] w_pop_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0000_0820;
    if (a == 32'h4) return 32'h2001_0001;
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  // ---------------- stimulus knobs ----------------
  int          lat_min = 0, lat_max = 0, ready_pct = 100, redir_pct = 0, stray_pct = 0;
  bit          reset_ack = 1'b0;
  int          trig_mode = 0, trig_wait = 0;
  logic [31:0] trig_addr = '0, trig_pc = '0;
  int          trig_ack_idx = 0, trig_pop_idx = 0;

  int          wait_cnt = 0, lat_target = 0;
  logic [31:0] exp_pc = '0, prev_addr = '0;
  bit          prev_req = 1'b0, prev_ack = 1'b0, after_redir = 1'b0;

  // ---------------- memory driver + stream model ----------------
  always @(negedge clk) begin
    if (reset) begin
      imem_ack    = reset_ack;
      imem_rdata  = $urandom;
      inst_ready  = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;
      wait_cnt    = 0;
      lat_target  = lat_min;
      exp_pc      = 32'h0;
      prev_req    = 1'b0;
      prev_ack    = 1'b0;
      after_redir = 1'b0;
    end else begin
      imem_ack    = 1'b0;
      imem_rdata  = $urandom;
      redirect    = 1'b0;
      redirect_pc = $urandom;
      if (imem_req) begin
        if (prev_req && !prev_ack) check_eq("addr_stable", imem_addr, prev_addr);
        if (trig_mode == 1 && imem_addr == trig_addr && wait_cnt == trig_wait) begin
          redirect    = 1'b1;
          redirect_pc = trig_pc;
          trig_mode   = 0;
        end
        if (wait_cnt >= lat_target) begin
          imem_ack   = 1'b1;
          imem_rdata = mem_word(imem_addr);
          wait_cnt   = 0;
          lat_target = $urandom_range(lat_max, lat_min);
        end else begin
          wait_cnt++;
        end
      end else if (stray_pct > 0 && $urandom_range(0, 99) < stray_pct) begin
        imem_ack = 1'b1;
      end
      inst_ready = ($urandom_range(0, 99) < ready_pct);
      if (!redirect && redir_pct > 0 && $urandom_range(0, 99) < redir_pct) begin
        redirect    = 1'b1;
        redirect_pc = $urandom_range(0, 1023);
      end
      #1;
      if (trig_mode == 2 && !redirect && imem_req && imem_ack && inst_valid && inst_ready) begin
        redirect     = 1'b1;
        redirect_pc  = trig_pc;
        trig_mode    = 0;
        trig_ack_idx = ack_q.size();
        trig_pop_idx = pop_q.size();
      end
      #1;
`ifndef IFU_BYPASS_EN
      if (after_redir) check_eq("valid_after_redirect", 32'(inst_valid), 32'd0);
`endif
      if (inst_valid) begin
        check_eq("inst_pc", inst_pc, exp_pc);
        check_eq("inst", inst, mem_word(exp_pc));
      end
      if (inst_valid && inst_ready) begin
        pop_q.push_back(inst_pc);
        exp_pc = exp_pc + 32'd4;
      end
      if (redirect) exp_pc = redirect_pc & ~32'h3;
      if (imem_req && imem_ack) ack_q.push_back(imem_addr);
      after_redir = redirect;
      prev_req    = imem_req;
      prev_ack    = imem_ack;
      prev_addr   = imem_addr;
    end
  end

  // Wrap instance: zero-wait memory, decode always ready.
  always @(negedge clk) begin
    w_ack   = w_req && !reset;
    w_rdata = mem_word(w_addr);
    #2;
    if (!reset) begin
      if (w_req && w_ack && w_ack_q.size() < 3) w_ack_q.push_back(w_addr);
      if (w_valid && w_pop_q.size() < 3) begin
        w_pop_q.push_back(w_pc);
        check_eq("wrap_inst", w_inst, mem_word(w_pc));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic reset_hold(input int n);
    @(posedge clk);
    #2;
    reset = 1'b1;
    step(n);
  endtask

  task automatic release_reset();
    ack_q.delete();
    pop_q.delete();
    reset = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req"},   32'(imem_req),   32'd0);
    check_eq({tag, "_addr"},  imem_addr,       32'h0);
    check_eq({tag, "_valid"}, 32'(inst_valid), 32'd0);
    check_eq({tag, "_inst"},  inst,            32'h0);
    check_eq({tag, "_pc"},    inst_pc,         32'h0);
    check_eq({tag, "_state"}, 32'(fsm_state),  32'(IFU_IDLE));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int n8;
    bit fired;

    // Zero-wait memory, decode always ready.
    lat_min = 0; lat_max = 0; ready_pct = 100;
    reset_hold(3);
    check_reset_outputs("rst");
    release_reset();
    check_eq("req_before_edge", 32'(imem_req), 32'd0);
    step(1);
    check_eq("first_req", 32'(imem_req), 32'd1);
    check_eq("first_addr", imem_addr, 32'h0);
`ifndef IFU_BYPASS_EN
    check_eq("first_valid", 32'(inst_valid), 32'd0);
    step(1);
    check_eq("c2_addr", imem_addr, 32'h4);
    check_eq("c2_pc", inst_pc, 32'h0);
    check_eq("c2_inst", inst, 32'h0000_0820);
    step(1);
    check_eq("c3_addr", imem_addr, 32'h8);
    check_eq("c3_pc", inst_pc, 32'h4);
    check_eq("c3_inst", inst, 32'h2001_0001);
`endif
    step(8);
    check_eq("zw_ack_n", 32'(ack_q.size() >= 3), 32'd1);
    if (ack_q.size() >= 3 && pop_q.size() >= 3) begin
      for (int i = 0; i < 3; i++) begin
        check_eq("zw_ack_addr", ack_q[i], 32'(4 * i));
        check_eq("zw_pop_pc", pop_q[i], 32'(4 * i));
      end
    end

    // Decode stalled: exactly DEPTH fetches, then the request stops.
    ready_pct = 0;
    reset_hold(2);
    release_reset();
    step(10);
    check_eq("stall_acks", 32'(ack_q.size()), 32'd4);
    check_eq("stall_req", 32'(imem_req), 32'd0);
    check_eq("stall_valid", 32'(inst_valid), 32'd1);
    check_eq("stall_head", inst_pc, 32'h0);
    exp_q = {32'h0, 32'h4, 32'h8, 32'hC};
    ready_pct = 100;
    step(10);
    check_eq("stall_pops", 32'(pop_q.size() >= 4), 32'd1);
    for (int i = 0; i < 4 && i < pop_q.size(); i++) begin
      check_eq("stall_order", pop_q[i], exp_q.pop_front());
    end

    // 3-cycle latency, redirect to 0x40 in the 2nd cycle of the request to 0x8.
    lat_min = 3; lat_max = 3;
    trig_mode = 1; trig_addr = 32'h8; trig_wait = 1; trig_pc = 32'h40;
    reset_hold(2);
    release_reset();
    step(40);
    check_eq("t3_fired", 32'(trig_mode), 32'd0);
    if (ack_q.size() >= 4) begin
      check_eq("t3_ack0", ack_q[0], 32'h0);
      check_eq("t3_ack1", ack_q[1], 32'h4);
      check_eq("t3_ack2_held", ack_q[2], 32'h8);
      check_eq("t3_ack3_new", ack_q[3], 32'h40);
    end else begin
      check_eq("t3_ack_n", 32'(ack_q.size()), 32'd4);
    end
    n8 = 0;
    foreach (pop_q[i]) if (pop_q[i] == 32'h8) n8++;
    check_eq("t3_no_8", 32'(n8), 32'd0);
    if (pop_q.size() >= 3) check_eq("t3_pop2", pop_q[2], 32'h40);
    else check_eq("t3_pop_n", 32'(pop_q.size()), 32'd3);

    // Redirect coinciding with an ack and a pop.
    lat_min = 0; lat_max = 0;
    trig_mode = 2; trig_pc = 32'h200;
    reset_hold(2);
    release_reset();
    step(20);
    check_eq("t4_fired", 32'(trig_mode), 32'd0);
    if (ack_q.size() > trig_ack_idx + 1 && pop_q.size() > trig_pop_idx + 1) begin
      check_eq("t4_next_fetch", ack_q[trig_ack_idx + 1], 32'h200);
      check_eq("t4_next_pop", pop_q[trig_pop_idx + 1], 32'h200);
    end else begin
      check_eq("t4_progress", 32'd0, 32'd1);
    end

    // Reset while in DROP; a stray ack afterwards must not push.
    lat_min = 6; lat_max = 6;
    trig_mode = 1; trig_addr = 32'h0; trig_wait = 0; trig_pc = 32'h80;
    reset_hold(2);
    release_reset();
    fired = 1'b0;
    for (int i = 0; i < 20 && !fired; i++) begin
      step(1);
      fired = (trig_mode == 0);
    end
    check_eq("t6_fired", 32'(fired), 32'd1);
    check_eq("t6_in_drop", 32'(fsm_state), 32'(IFU_DROP));
    check_eq("t6_drop_addr", imem_addr, 32'h0);
    reset_ack = 1'b1;
    reset = 1'b1;
    step(1);
    check_reset_outputs("drop_rst");
    step(1);
    reset_ack = 1'b0;
    stray_pct = 100;
    release_reset();
    step(1);
    stray_pct = 0;
    check_eq("t6_no_push", 32'(inst_valid), 32'd0);
    check_eq("t6_req", 32'(imem_req), 32'd1);
    check_eq("t6_addr", imem_addr, 32'h0);
    step(30);
    if (pop_q.size() > 0) check_eq("t6_first_pop", pop_q[0], 32'h0);
    else check_eq("t6_pop_n", 32'd0, 32'd1);

    // Randomized run.
    lat_min = 0; lat_max = 3; ready_pct = 75; redir_pct = 4; stray_pct = 30;
    reset_hold(2);
    release_reset();
    step(3000);
    check_eq("rand_progress", 32'(pop_q.size() > 200), 32'd1);

    // Fetch address wrap from RESET_PC = FFFF_FFF8.
    exp_q = {32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0};
    check_eq("wrap_ack_n", 32'(w_ack_q.size()), 32'd3);
    check_eq("wrap_pop_n", 32'(w_pop_q.size()), 32'd3);
    for (int i = 0; i < 3 && i < w_ack_q.size() && i < w_pop_q.size(); i++) begin
      check_eq("wrap_addr", w_ack_q[i], exp_q[i]);
      check_eq("wrap_pc", w_pop_q[i], exp_q[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
